// File: rtl/zion_basic_circuit_lib_pkg.sv
// rtl/zion_basic_circuit_lib_pkg.sv - shared helpers for the basic circuit library
package zion_basic_circuit_lib_pkg;

    // Width needed to hold a count from 0 to n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/zion_basic_circuit_lib_pipe_ctrl_stg.sv
// rtl/zion_basic_circuit_lib_pipe_ctrl_stg.sv - one pipeline stage: valid bit, ready, load enable and clear
module zion_basic_circuit_lib_pipe_ctrl_stg #(
    parameter bit CLR_ON_DRAIN = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic iFlush,
    input  logic iIn,
    input  logic iRdyNxt,
    output logic oRdy,
    output logic oVld,
    output logic oEn,
    output logic oClr
);

    logic vld;

    // A stage can accept when it is empty or its content moves on this edge.
    assign oRdy = !vld | iRdyNxt;
    assign oEn  = oRdy & iIn & !iFlush;
    assign oVld = vld;

    // Clear on flush; optionally clear when the content leaves and nothing replaces it.
    always_comb begin
        oClr = 1'b0;
        if (iFlush) begin
            oClr = 1'b1;
        end else if (CLR_ON_DRAIN) begin
            oClr = vld & iRdyNxt & !iIn & oRdy;
        end
    end

    // Valid bit follows the upstream valid whenever the stage is allowed to move.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= 1'b0;
        end else if (iFlush) begin
            vld <= 1'b0;
        end else if (oRdy) begin
            vld <= iIn;
        end
    end

endmodule

// File: rtl/zion_basic_circuit_lib_pipe_ctrl.sv
// rtl/zion_basic_circuit_lib_pipe_ctrl.sv - valid/ready sequencer for a chain of clearable data registers
module zion_basic_circuit_lib_pipe_ctrl
    import zion_basic_circuit_lib_pkg::*;
#(
    parameter int STAGE_NUM    = 4,
    parameter int CLR_ON_DRAIN = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 iValid,
    output logic                                 oReady,
    output logic                                 oValid,
    input  logic                                 iReady,
    input  logic                                 iFlush,
    output logic [STAGE_NUM-1:0]                 oEn,
    output logic [STAGE_NUM-1:0]                 oClr,
    output logic [STAGE_NUM-1:0]                 oStgVld,
    output logic [cnt_width(STAGE_NUM)-1:0]      oCnt
);

    localparam int CW = cnt_width(STAGE_NUM);

    logic [STAGE_NUM:0]   rdy;
    logic [STAGE_NUM-1:0] stg_in;
    logic [STAGE_NUM-1:0] vld;
    logic [CW-1:0]        cnt;
    logic                 in_xfer;
    logic                 out_xfer;

    assign rdy[STAGE_NUM] = iReady;
    assign stg_in[0]      = iValid;

    for (genvar i = 0; i < STAGE_NUM; i++) begin : g_stg
        if (i > 0) begin : g_link
            assign stg_in[i] = vld[i-1];
        end
        zion_basic_circuit_lib_pipe_ctrl_stg #(
            .CLR_ON_DRAIN (CLR_ON_DRAIN != 0)
        ) u_stg (
            .clk     (clk),
            .rst     (rst),
            .iFlush  (iFlush),
            .iIn     (stg_in[i]),
            .iRdyNxt (rdy[i+1]),
            .oRdy    (rdy[i]),
            .oVld    (vld[i]),
            .oEn     (oEn[i]),
            .oClr    (oClr[i])
        );
    end

    // Flush blocks both handshakes so neither side sees a transfer.
    assign oReady   = rdy[0] & !iFlush;
    assign oValid   = vld[STAGE_NUM-1] & !iFlush;
    assign in_xfer  = iValid & oReady;
    assign out_xfer = oValid & iReady;
    assign oStgVld  = vld;
    assign oCnt     = cnt;

    // Occupancy counter tracks accepted minus delivered items.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (iFlush) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(in_xfer) - CW'(out_xfer);
        end
    end

endmodule
